dma_writer: RTL and testbench
=============================

// Module: dma_writer
// PURPOSE
//  Write-back DMA for the fully-connected datapath: drains a parallel result buffer into word-addressed memory.
//  One word per clock, at consecutive addresses from a start address, after a single-cycle start request.
//  Sits between the FC output buffer and the shared memory write port. Mirror of the input-side DMA (memory -> buffer).
// PARAMETERS
//  BUFFER_SIZE        120  number of words in i_buffer; max transfer length
//  WORD_SIZE          16   data word width in bits
//  MEM_ADDRESS_WIDTH  10   memory word-address width
// PORTS
//  clk          in   1                        clock; all state updates on posedge
//  rst_n        in   1                        asynchronous active-low reset
//  i_write      in   1                        start request; sampled only in IDLE
//  i_address    in   MEM_ADDRESS_WIDTH        start address, captured with i_write
//  i_count      in   MEM_ADDRESS_WIDTH        words to write, captured with i_write
//  i_buffer     in   WORD_SIZE x BUFFER_SIZE  source words; index k goes to address start+k
//  o_mem_addr   out  MEM_ADDRESS_WIDTH        memory write address
//  o_mem_data   out  WORD_SIZE                memory write data
//  o_mem_write  out  1                        write strobe; one word per asserted cycle
//  o_busy       out  1                        high from cycle after accepted start until o_done
//  o_done       out  1                        single-cycle completion pulse
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; idx, count, address cleared; all outputs 0. Abort mid-transfer: no further writes.
//  - All outputs registered. FSM: IDLE -> WRITE -> DONE -> IDLE.
//  - IDLE: if i_write=1, capture i_address, count=min(i_count, BUFFER_SIZE), idx=0.
//    count=0 -> DONE (no writes); else -> WRITE. o_busy=1 the next cycle.
//  - WRITE: each cycle the word is accepted, drive o_mem_write=1, o_mem_addr=address+idx, o_mem_data=i_buffer[idx],
//    then idx++. On the beat with idx=count-1 -> DONE.
//  - First write strobe: exactly 1 cycle after the start edge. Exactly count strobes, no gaps (without backpressure).
//  - DONE: o_done=1 for one cycle, o_busy=0, o_mem_write=0 -> IDLE. New start accepted the following cycle.
//  - Address arithmetic: modulo 2^MEM_ADDRESS_WIDTH; wraps 2^N-1 -> 0 silently.
//  - i_count > BUFFER_SIZE: clamped to BUFFER_SIZE; never index past the buffer.
//  - i_write while o_busy or in DONE: ignored, not queued.
//  - i_buffer: must stay stable while o_busy=1; not snapshotted.
//  - o_mem_addr/o_mem_data: hold last value when o_mem_write=0 (don't-care to memory).
// CONFIGURATION
//  DMA_WR_BACKPRESSURE_EN defined:
//    - Adds input port i_mem_ready (1 bit).
//    - A beat completes only when o_mem_write && i_mem_ready.
//    - While i_mem_ready=0, hold o_mem_write, o_mem_addr and o_mem_data unchanged; idx does not advance.
//    - Reset still aborts the transfer.
//  Undefined:
//    - No i_mem_ready port; memory accepts every cycle (i_mem_ready treated as 1).
// TESTING
//  - Reset then idle: all outputs 0. Assert rst_n mid-transfer at beat 3 of 8: o_mem_write=0 immediately, no o_done.
//  - Basic: start addr=0x010, count=4, buf[k]=0xA000+k:
//    - writes 0x010..0x013 with 0xA000..0xA003 on cycles 1..4 after start;
//    - o_done on cycle 5.
//  - count=0: no o_mem_write; o_done one cycle after DONE entry (cycle 2); o_busy never asserted past the DONE cycle.
//  - Wrap and clamp:
//    - addr=0x3FE, count=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001;
//    - count=200 -> exactly 120 writes.
//  - Ignored start: pulse i_write mid-transfer with other addr/count -> original transfer unchanged, no second transfer.
//  - DMA_WR_BACKPRESSURE_EN: count=3, i_mem_ready low 2 cycles on beat 1 -> beat 1 held stable, 3 writes total, o_done 2 cycles later.

Source files
------------

// File: rtl/dma_writer_if.sv
// Memory write-port bundle between dma_writer (master) and the shared memory (slave).
// DMA_WR_BACKPRESSURE_EN adds the i_mem_ready return signal.
interface dma_writer_if #(
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int WORD_SIZE         = 16
);
    // Handshake: a beat is the cycle o_mem_write=1; it completes on the rising edge where
    // i_mem_ready=1 (tied high when backpressure is absent). While o_mem_write=1 and
    // i_mem_ready=0 the master holds o_mem_addr/o_mem_data/o_mem_write unchanged.
    logic [MEM_ADDRESS_WIDTH-1:0] o_mem_addr;
    logic [WORD_SIZE-1:0]         o_mem_data;
    logic                         o_mem_write;
`ifdef DMA_WR_BACKPRESSURE_EN
    logic                         i_mem_ready;
`endif

    modport master (
        output o_mem_addr, o_mem_data, o_mem_write
`ifdef DMA_WR_BACKPRESSURE_EN
        , input i_mem_ready
`endif
    );

    modport slave (
        input o_mem_addr, o_mem_data, o_mem_write
`ifdef DMA_WR_BACKPRESSURE_EN
        , output i_mem_ready
`endif
    );
endinterface

// File: rtl/dma_writer.sv
// Write-back DMA: drains a parallel result buffer into consecutive memory words, one per clock.
// Optional memory backpressure via macro DMA_WR_BACKPRESSURE_EN.
module dma_writer #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_write,
    input  logic [MEM_ADDRESS_WIDTH-1:0] i_address,
    input  logic [MEM_ADDRESS_WIDTH-1:0] i_count,
    input  logic [WORD_SIZE-1:0]         i_buffer [BUFFER_SIZE],
    dma_writer_if.master                 mem,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [1:0]                   o_dbg_state
);

    localparam int AW   = MEM_ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int BI_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        base_q, base_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     clamp_cnt;
    logic                 mem_ready;
    logic                 beat_ok;

`ifdef DMA_WR_BACKPRESSURE_EN
    assign mem_ready = mem.i_mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    assign beat_ok = wr_q && mem_ready;

    always_comb begin
        clamp_cnt = i_count[CNT_W-1:0];
        if (i_count > AW'(BUFFER_SIZE))
            clamp_cnt = CNT_W'(BUFFER_SIZE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // The state tracks the word being issued; outputs are registered one stage behind,
    // so DONE is entered on the edge that issues the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q still high means the previous transfer is in its completion cycle
                if (i_write && !done_q) begin
                    base_d = i_address;
                    cnt_d  = clamp_cnt;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (clamp_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        wr_d    = 1'b1;
                        addr_d  = i_address;
                        data_d  = i_buffer[0];
                        idx_d   = CNT_W'(1);
                        state_d = (clamp_cnt == CNT_W'(1)) ? S_DONE : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (beat_ok) begin
                    addr_d = base_q + AW'(idx_q);
                    data_d = i_buffer[idx_q[BI_W-1:0]];
                    idx_d  = idx_q + CNT_W'(1);
                    if (idx_q == cnt_q - CNT_W'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!wr_q || mem_ready) begin
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            base_q <= base_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wr_q   <= wr_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign mem.o_mem_addr  = addr_q;
    assign mem.o_mem_data  = data_q;
    assign mem.o_mem_write = wr_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_dma_writer.sv
// Directed bench for dma_writer: table of transfers plus reset-abort sequence.
module tb_dma_writer;

    logic        clk;
    logic        rst_n;
    logic        i_write;
    logic [9:0]  i_address;
    logic [9:0]  i_count;
    logic [15:0] buffer [120];
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_dbg_state;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    dma_writer_if #(.MEM_ADDRESS_WIDTH(10), .WORD_SIZE(16)) bus ();

`ifdef DMA_WR_BACKPRESSURE_EN
    assign bus.i_mem_ready = mem_ready;
`endif

    dma_writer #(
        .BUFFER_SIZE(120), .WORD_SIZE(16), .MEM_ADDRESS_WIDTH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_write(i_write), .i_address(i_address),
        .i_count(i_count), .i_buffer(buffer), .mem(bus),
        .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [9:0]  cnt;
        logic [15:0] seed;
        int          exp_writes;
        int          exp_done_cyc;
        logic [9:0]  exp_last_addr;
        int          intr_cyc;
        int          stall_cyc;
        int          stall_len;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [25:0] exp_q[$];
        int n_strobe = 0;
        int n_acc    = 0;
        int n_done   = 0;
        int done_cyc = -1;
        int busy_err = 0;
        for (int k = 0; k < 120; k++) buffer[k] = v.seed + 16'(k);
        for (int k = 0; k < v.exp_writes; k++)
            exp_q.push_back({v.addr + 10'(k), v.seed + 16'(k)});
        @(negedge clk);
        i_write = 1'b1; i_address = v.addr; i_count = v.cnt;
        @(negedge clk);
        i_write = 1'b0;
        i_address = 10'($urandom_range(0, 1023));
        i_count   = 10'($urandom_range(0, 1023));
        for (int c = 1; c <= v.exp_done_cyc + 3; c++) begin
            if (c == v.intr_cyc) begin
                i_write = 1'b1; i_address = 10'h200; i_count = 10'd3;
            end else begin
                i_write = 1'b0;
            end
            mem_ready = !(c >= v.stall_cyc && c < v.stall_cyc + v.stall_len);
            if (bus.o_mem_write) begin
                n_strobe++;
                check("strobe_cycle", c, n_strobe);
                if (exp_q.size() == 0) begin
                    check("extra_write", n_strobe, v.exp_writes);
                end else begin
                    check("wr_addr", int'(bus.o_mem_addr), int'(exp_q[0][25:16]));
                    check("wr_data", int'(bus.o_mem_data), int'(exp_q[0][15:0]));
                    if (mem_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end
            if (o_done) begin
                n_done++;
                done_cyc = c;
            end
            if (o_busy !== (c < v.exp_done_cyc)) busy_err++;
            @(negedge clk);
        end
        i_write = 1'b0;
        mem_ready = 1'b1;
        check("write_count", n_acc, v.exp_writes);
        check("done_cycle", done_cyc, v.exp_done_cyc);
        check("done_pulses", n_done, 1);
        check("busy_window_errors", busy_err, 0);
        check("pending_writes", exp_q.size(), 0);
        check("idle_state", int'(o_dbg_state), 0);
        if (v.exp_writes > 0)
            check("addr_hold", int'(bus.o_mem_addr), int'(v.exp_last_addr));
    endtask

    initial begin
        int wr_seen;
        int done_seen;
        rst_n = 1'b0; i_write = 1'b0; i_address = '0; i_count = '0; mem_ready = 1'b1;
        for (int k = 0; k < 120; k++) buffer[k] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_write", int'(bus.o_mem_write), 0);
        check("rst_mem_addr", int'(bus.o_mem_addr), 0);
        check("rst_mem_data", int'(bus.o_mem_data), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_state", int'(o_dbg_state), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_mem_write", int'(bus.o_mem_write), 0);
        check("idle_busy", int'(o_busy), 0);

        //                   addr     cnt      seed      wr   done last     intr stall len
        vecs.push_back(vec_t'{10'h010, 10'd4,   16'hA000, 4,   5,   10'h013, 0,   0,    0});
        vecs.push_back(vec_t'{10'h100, 10'd1,   16'h1234, 1,   2,   10'h100, 0,   0,    0});
        vecs.push_back(vec_t'{10'h020, 10'd0,   16'h5500, 0,   2,   10'h000, 0,   0,    0});
        vecs.push_back(vec_t'{10'h3FE, 10'd4,   16'hB000, 4,   5,   10'h001, 0,   0,    0});
        vecs.push_back(vec_t'{10'h000, 10'd200, 16'hC000, 120, 121, 10'h077, 0,   0,    0});
        vecs.push_back(vec_t'{10'h300, 10'd120, 16'h0F00, 120, 121, 10'h377, 0,   0,    0});
        vecs.push_back(vec_t'{10'h080, 10'd5,   16'hD000, 5,   6,   10'h084, 2,   0,    0});
`ifdef DMA_WR_BACKPRESSURE_EN
        vecs.push_back(vec_t'{10'h050, 10'd3,   16'hE000, 3,   6,   10'h052, 0,   2,    2});
        vecs.push_back(vec_t'{10'h3FF, 10'd2,   16'h7700, 2,   5,   10'h000, 0,   2,    2});
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while the third of eight beats is on the bus
        for (int k = 0; k < 120; k++) buffer[k] = 16'h4000 + 16'(k);
        @(negedge clk);
        i_write = 1'b1; i_address = 10'h040; i_count = 10'd8;
        @(negedge clk);
        i_write = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_write", int'(bus.o_mem_write), 1);
        check("pre_abort_addr", int'(bus.o_mem_addr), 10'h042);
        rst_n = 1'b0;
        #1;
        check("abort_mem_write", int'(bus.o_mem_write), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_seen = 0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.o_mem_write) wr_seen++;
            if (o_done) done_seen++;
            @(negedge clk);
        end
        check("post_abort_writes", wr_seen, 0);
        check("post_abort_done", done_seen, 0);

        // Transfer right after the abort still works
        run_vec(vec_t'{10'h1F0, 10'd3, 16'h9990, 3, 4, 10'h1F2, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
